// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store stage:
//   - field positions inside the 4-bit mem_op bundle
//   - access size encodings
//   - load/store FSM state type
//   - width of the bus timeout counter
//   - helper that classifies an access as misaligned
// ---------------------------------------------------------------------------
package lsu_pkg;

    // mem_op = {is_mem, store, size[1:0]}
    localparam int MOP_IS_MEM = 3;
    localparam int MOP_STORE  = 2;
    localparam int MOP_SZ_HI  = 1;
    localparam int MOP_SZ_LO  = 0;

    // Access sizes. SZ_BU is a byte access that is always zero-extended
    // on loads, independent of mem_uns.
    localparam logic [1:0] SZ_B  = 2'b00;
    localparam logic [1:0] SZ_H  = 2'b01;
    localparam logic [1:0] SZ_W  = 2'b10;
    localparam logic [1:0] SZ_BU = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } lsu_state_e;

    // TIMEOUT may be as large as 255; the counter only needs to reach
    // TIMEOUT-1, so 8 bits always suffice.
    localparam int TO_CNT_W = 8;

    // Halfwords need an even address, words a multiple of four. Bytes
    // can never be misaligned.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if (size == SZ_H && off[0]) begin
            mis = 1'b1;
        end
        if (size == SZ_W && off != 2'b00) begin
            mis = 1'b1;
        end
        return mis;
    endfunction

endpackage

// File: rtl/lsu_stage_align.sv
// ---------------------------------------------------------------------------
// lsu_stage_align
// Purely combinational lane formatter for the load/store stage.
//
// Ports:
//   addr_lo_i  byte offset of the access inside its 32-bit word
//   size_i     access size (SZ_B / SZ_H / SZ_W / SZ_BU)
//   uns_i      zero-extend loads when set
//   st_data_i  raw store data (rs2)
//   ld_data_i  raw load word from the data bus
//   be_o       byte enables for the access
//   wdata_o    store data replicated across every lane it could land in
//   ld_ext_o   selected load lane, sign- or zero-extended to 32 bits
// ---------------------------------------------------------------------------
module lsu_stage_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_ext_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        zext;

    // Pick the addressed byte / halfword out of the loaded word. Only
    // aligned halfwords reach here, so addr_lo_i[1] alone selects one.
    always_comb begin
        lane_b = ld_data_i[7:0];
        case (addr_lo_i)
            2'd0:    lane_b = ld_data_i[7:0];
            2'd1:    lane_b = ld_data_i[15:8];
            2'd2:    lane_b = ld_data_i[23:16];
            default: lane_b = ld_data_i[31:24];
        endcase
        lane_h = addr_lo_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];
    end

    assign zext = uns_i || (size_i == SZ_BU);

    always_comb begin
        be_o     = 4'b0000;
        wdata_o  = st_data_i;
        ld_ext_o = ld_data_i;
        case (size_i)
            SZ_W: begin
                be_o     = 4'b1111;
                wdata_o  = st_data_i;
                ld_ext_o = ld_data_i;
            end
            SZ_H: begin
                be_o     = 4'b0011 << addr_lo_i;
                wdata_o  = {2{st_data_i[15:0]}};
                ld_ext_o = zext ? {16'h0000, lane_h}
                                : {{16{lane_h[15]}}, lane_h};
            end
            default: begin
                // SZ_B and SZ_BU share lane handling; only extension differs.
                be_o     = 4'b0001 << addr_lo_i;
                wdata_o  = {4{st_data_i[7:0]}};
                ld_ext_o = zext ? {24'h000000, lane_b}
                                : {{24{lane_b[7]}}, lane_b};
            end
        endcase
    end

endmodule

// File: rtl/lsu_stage.sv
// ---------------------------------------------------------------------------
// lsu_stage
// Load/store pipeline stage sitting directly after execute. Non-memory ops
// pass through with one cycle of latency; memory ops perform a single
// data-memory transaction and then retire. Misaligned accesses and bus
// timeouts retire immediately with a flag and no register write.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   valid_in              execute presents an op this cycle
//   alu_out               effective address or arithmetic result
//   rs2_data              store data
//   mem_op                {is_mem, store, size[1:0]}
//   mem_uns               zero-extend loads
//   rd_in, reg_we_in      destination register and its write enable
//   stall_out             upstream must hold (transaction outstanding)
//   dmem_req/we/addr/
//   wdata/be              data-memory request side
//   dmem_rdata, dmem_ack  data-memory response side
//   wb_valid/we/rd/data   registered writeback bundle, 1-cycle pulse per op
//   misalign, bus_err     1-cycle flags accompanying wb_valid
//
// Data-memory handshake: dmem_req rises on the edge after an aligned
// memory op is accepted and stays high, with dmem_we/addr/wdata/be frozen,
// until the cycle in which dmem_ack is sampled high (that cycle completes
// the transfer and dmem_rdata is taken then) or until the timeout expires.
// dmem_req falls on the following edge. Acks outside a request are ignored.
// ---------------------------------------------------------------------------
module lsu_stage
    import lsu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic [3:0]       mem_op,
    input  logic             mem_uns,
    input  logic [4:0]       rd_in,
    input  logic             reg_we_in,
    output logic             stall_out,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    output logic [3:0]       dmem_be,
    input  logic [WIDTH-1:0] dmem_rdata,
    input  logic             dmem_ack,
    output logic             wb_valid,
    output logic             wb_we,
    output logic [4:0]       wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             misalign,
    output logic             bus_err
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    lsu_state_e          state_q,    state_d;
    logic [TO_CNT_W-1:0] cnt_q,      cnt_d;

    // Transaction registers, captured when an aligned op is accepted.
    logic [WIDTH-1:0]    addr_q,     addr_d;   // full address; low bits pick the load lane
    logic [WIDTH-1:0]    wdata_q,    wdata_d;
    logic [3:0]          be_q,       be_d;
    logic [4:0]          rd_q,       rd_d;
    logic                reg_we_q,   reg_we_d;
    logic                store_q,    store_d;
    logic [1:0]          size_q,     size_d;
    logic                uns_q,      uns_d;

    // Writeback bundle registers.
    logic                wb_valid_q, wb_valid_d;
    logic                wb_we_q,    wb_we_d;
    logic [4:0]          wb_rd_q,    wb_rd_d;
    logic [WIDTH-1:0]    wb_data_q,  wb_data_d;
    logic                misalign_q, misalign_d;
    logic                bus_err_q,  bus_err_d;

    // ------------------------------------------------------------------
    // Lane formatting. One formatter serves both phases: in IDLE it
    // builds byte enables and store data from the incoming op, in WAIT
    // it extracts the load lane using the captured offset and size.
    // ------------------------------------------------------------------
    logic [1:0]       al_off;
    logic [1:0]       al_size;
    logic             al_uns;
    logic [3:0]       al_be;
    logic [WIDTH-1:0] al_wdata;
    logic [WIDTH-1:0] al_ld;

    always_comb begin
        al_off  = alu_out[1:0];
        al_size = mem_op[MOP_SZ_HI:MOP_SZ_LO];
        al_uns  = mem_uns;
        if (state_q == WAIT) begin
            al_off  = addr_q[1:0];
            al_size = size_q;
            al_uns  = uns_q;
        end
    end

    lsu_stage_align u_align (
        .addr_lo_i (al_off),
        .size_i    (al_size),
        .uns_i     (al_uns),
        .st_data_i (rs2_data),
        .ld_data_i (dmem_rdata),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .ld_ext_o  (al_ld)
    );

    // ------------------------------------------------------------------
    // Next-state and writeback logic
    // ------------------------------------------------------------------
    logic timeout_hit;
    assign timeout_hit = (cnt_q == TO_CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rd_d       = rd_q;
        reg_we_d   = reg_we_q;
        store_d    = store_q;
        size_d     = size_q;
        uns_d      = uns_q;

        // Writeback is a pulse: anything not completing this cycle
        // leaves the bundle at zero.
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_rd_d    = 5'd0;
        wb_data_d  = '0;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (!mem_op[MOP_IS_MEM]) begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = reg_we_in;
                        wb_rd_d    = rd_in;
                        wb_data_d  = alu_out;
                    end else if (is_misaligned(mem_op[MOP_SZ_HI:MOP_SZ_LO],
                                               alu_out[1:0])) begin
                        // Retire without touching the bus or the register file.
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_in;
                        misalign_d = 1'b1;
                    end else begin
                        state_d  = WAIT;
                        cnt_d    = '0;
                        addr_d   = alu_out;
                        wdata_d  = al_wdata;
                        be_d     = al_be;
                        rd_d     = rd_in;
                        reg_we_d = reg_we_in;
                        store_d  = mem_op[MOP_STORE];
                        size_d   = mem_op[MOP_SZ_HI:MOP_SZ_LO];
                        uns_d    = mem_uns;
                    end
                end
            end

            WAIT: begin
                // An ack arriving in the expiry cycle still completes normally.
                if (dmem_ack) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    if (!store_q) begin
                        wb_we_d   = reg_we_q;
                        wb_data_d = al_ld;
                    end
                end else if (timeout_hit) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    bus_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= 4'b0000;
            rd_q       <= 5'd0;
            reg_we_q   <= 1'b0;
            store_q    <= 1'b0;
            size_q     <= SZ_B;
            uns_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            rd_q       <= rd_d;
            reg_we_q   <= reg_we_d;
            store_q    <= store_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign stall_out  = (state_q == WAIT);
    assign dmem_req   = (state_q == WAIT);
    assign dmem_we    = (state_q == WAIT) && store_q;
    assign dmem_addr  = {addr_q[WIDTH-1:2], 2'b00};
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;

    assign wb_valid   = wb_valid_q;
    assign wb_we      = wb_we_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign misalign   = misalign_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_lsu_stage.sv
// ---------------------------------------------------------------------------
// tb_lsu_stage
// Self-checking bench for lsu_stage: directed scenarios plus a randomized
// op stream compared against a behavioural model of the stage.
// ---------------------------------------------------------------------------
module tb_lsu_stage;

    localparam int TIMEOUT = 16;
    localparam int NEVER   = 1000;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [31:0] alu_out;
    logic [31:0] rs2_data;
    logic [3:0]  mem_op;
    logic        mem_uns;
    logic [4:0]  rd_in;
    logic        reg_we_in;
    logic        stall_out;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign;
    logic        bus_err;

    always #5 clk = ~clk;

    lsu_stage #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .alu_out    (alu_out),
        .rs2_data   (rs2_data),
        .mem_op     (mem_op),
        .mem_uns    (mem_uns),
        .rd_in      (rd_in),
        .reg_we_in  (reg_we_in),
        .stall_out  (stall_out),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .wb_valid   (wb_valid),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .misalign   (misalign),
        .bus_err    (bus_err)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    // ---------------- reference model ----------------
    function automatic logic m_misalign(input int sz, input logic [31:0] a);
        return (sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0);
    endfunction

    function automatic logic [3:0] m_be(input int sz, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (sz == 2) return 4'hF;
        if (sz == 1) return 4'(3 << off);
        return 4'(1 << off);
    endfunction

    function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] d);
        if (sz == 2) return d;
        if (sz == 1) return (d & 32'h0000_FFFF) * 32'h0001_0001;
        return (d & 32'h0000_00FF) * 32'h0101_0101;
    endfunction

    function automatic logic [31:0] m_load(input int sz, input logic uns,
                                           input logic [31:0] a, input logic [31:0] rdata);
        logic [31:0] v;
        if (sz == 2) return rdata;
        v = rdata >> (8 * (a % 4));
        if (sz == 1) begin
            v = v & 32'h0000_FFFF;
            if (!uns && v >= 32'h0000_8000) v = v + 32'hFFFF_0000;
            return v;
        end
        v = v & 32'h0000_00FF;
        if (!uns && v >= 32'h0000_0080) v = v + 32'hFFFF_FF00;
        return v;
    endfunction

    // ---------------- driver ----------------
    int          o_req_cycles;
    logic        o_unstable, o_stall_bad, o_timeout;
    logic [31:0] o_addr, o_wdata;
    logic [3:0]  o_be;
    logic        o_we;
    logic        o_wb_valid, o_wb_we, o_misalign, o_bus_err, o_after;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;

    task automatic idle_inputs();
        valid_in  = 1'b0;
        alu_out   = '0;
        rs2_data  = '0;
        mem_op    = '0;
        mem_uns   = 1'b0;
        rd_in     = '0;
        reg_we_in = 1'b0;
        dmem_ack  = 1'b0;
        dmem_rdata = '0;
    endtask

    // Issues one op, services the bus (ack on WAIT cycle ack_after+1),
    // and records what the DUT did until the op retires.
    task automatic run_op(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] op, input logic uns,
                          input logic [4:0] rd, input logic we,
                          input int ack_after, input logic [31:0] rdata);
        bit done;
        @(negedge clk);
        valid_in = 1'b1; alu_out = a; rs2_data = d; mem_op = op;
        mem_uns = uns; rd_in = rd; reg_we_in = we;
        @(negedge clk);
        o_req_cycles = 0; o_unstable = 1'b0; o_stall_bad = 1'b0; done = 1'b0;
        o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (dmem_req) begin
                if (o_req_cycles == 0) begin
                    o_addr = dmem_addr; o_wdata = dmem_wdata; o_be = dmem_be; o_we = dmem_we;
                end else if (o_addr !== dmem_addr || o_wdata !== dmem_wdata ||
                             o_be !== dmem_be || o_we !== dmem_we) begin
                    o_unstable = 1'b1;
                end
                if (stall_out !== 1'b1) o_stall_bad = 1'b1;
                o_req_cycles++;
                dmem_ack   = (o_req_cycles == ack_after + 1);
                dmem_rdata = dmem_ack ? rdata : $urandom;
                // Inputs must be ignored while the transaction is outstanding.
                valid_in = 1'($urandom_range(0, 1)); alu_out = $urandom;
                rs2_data = $urandom; mem_op = 4'($urandom_range(0, 15));
                @(negedge clk);
                dmem_ack = 1'b0;
            end else begin
                valid_in = 1'b0;
                if (stall_out !== 1'b0) o_stall_bad = 1'b1;
                o_wb_valid = wb_valid; o_wb_we = wb_we; o_wb_rd = wb_rd;
                o_wb_data = wb_data; o_misalign = misalign; o_bus_err = bus_err;
                done = 1'b1;
            end
        end
        o_timeout = !done;
        @(negedge clk);
        o_after = wb_valid | misalign | bus_err;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        checks++;
        if ({stall_out, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
             wb_valid, wb_we, wb_rd, wb_data, misalign, bus_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: req=%b stall=%b wb_valid=%b wb_data=%h be=%b, all must be 0",
                     dmem_req, stall_out, wb_valid, wb_data, dmem_be);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu();
        run_op(32'h0000_1234, 32'h0, 4'b0000, 1'b0, 5'd5, 1'b1, NEVER, 32'h0);
        checks++;
        if (o_req_cycles !== 0) begin
            failures++; $display("FAIL alu_no_req: req_cycles=%0d expected 0", o_req_cycles);
        end
        checks++;
        if ({o_wb_valid, o_wb_we, o_misalign, o_bus_err} !== 4'b1100 ||
            o_wb_rd !== 5'd5 || o_wb_data !== 32'h0000_1234) begin
            failures++;
            $display("FAIL alu_wb: v/we/mis/err=%b%b%b%b rd=%0d data=%h expected 1100 rd=5 data=00001234",
                     o_wb_valid, o_wb_we, o_misalign, o_bus_err, o_wb_rd, o_wb_data);
        end
        checks++;
        if (o_after !== 1'b0) begin
            failures++; $display("FAIL alu_pulse: wb still valid next cycle (got %b, expected 0)", o_after);
        end
    endtask

    task automatic test_load();
        logic [31:0] e;
        for (int u = 0; u < 2; u++) begin
            run_op(32'h0000_0103, 32'h0, 4'b1000, 1'(u), 5'd9, 1'b1, 3, 32'h80AA_BBCC);
            e = (u == 0) ? 32'hFFFF_FF80 : 32'h0000_0080;
            checks++;
            if (o_addr !== 32'h0000_0100 || o_be !== 4'b1000 || o_we !== 1'b0) begin
                failures++;
                $display("FAIL lb_bus: addr=%h be=%b we=%b expected 00000100 1000 0", o_addr, o_be, o_we);
            end
            checks++;
            if (o_req_cycles !== 4 || o_stall_bad !== 1'b0) begin
                failures++;
                $display("FAIL lb_stall: req_cycles=%0d stall_bad=%b expected 4 0", o_req_cycles, o_stall_bad);
            end
            checks++;
            if (o_wb_valid !== 1'b1 || o_wb_we !== 1'b1 || o_wb_rd !== 5'd9 || o_wb_data !== e) begin
                failures++;
                $display("FAIL lb_wb uns=%0d: valid=%b we=%b rd=%0d data=%h expected 1 1 9 %h",
                         u, o_wb_valid, o_wb_we, o_wb_rd, o_wb_data, e);
            end
        end
    endtask

    task automatic test_store();
        run_op(32'h0000_0202, 32'h1234_5678, 4'b1101, 1'b0, 5'd4, 1'b1, 1, 32'hFFFF_FFFF);
        checks++;
        if (o_we !== 1'b1 || o_be !== 4'b1100 || o_wdata !== 32'h5678_5678 ||
            o_addr !== 32'h0000_0200 || o_unstable !== 1'b0) begin
            failures++;
            $display("FAIL sh_bus: we=%b be=%b wdata=%h addr=%h unstable=%b expected 1 1100 56785678 00000200 0",
                     o_we, o_be, o_wdata, o_addr, o_unstable);
        end
        checks++;
        if (o_wb_valid !== 1'b1 || o_wb_we !== 1'b0 || o_misalign !== 1'b0 || o_bus_err !== 1'b0) begin
            failures++;
            $display("FAIL sh_wb: valid=%b we=%b mis=%b err=%b expected 1 0 0 0",
                     o_wb_valid, o_wb_we, o_misalign, o_bus_err);
        end
    endtask

    task automatic test_misalign();
        run_op(32'h0000_0301, 32'h0, 4'b1010, 1'b0, 5'd6, 1'b1, 0, 32'h0);
        checks++;
        if (o_req_cycles !== 0) begin
            failures++; $display("FAIL mis_no_req: req_cycles=%0d expected 0", o_req_cycles);
        end
        checks++;
        if ({o_wb_valid, o_wb_we, o_misalign, o_bus_err} !== 4'b1010 || o_after !== 1'b0) begin
            failures++;
            $display("FAIL mis_wb: v/we/mis/err=%b%b%b%b after=%b expected 1010 after=0",
                     o_wb_valid, o_wb_we, o_misalign, o_bus_err, o_after);
        end
    endtask

    task automatic test_timeout();
        run_op(32'h0000_0400, 32'h0, 4'b1010, 1'b0, 5'd7, 1'b1, NEVER, 32'h0);
        checks++;
        if (o_req_cycles !== TIMEOUT || o_timeout !== 1'b0) begin
            failures++;
            $display("FAIL to_req_len: req_cycles=%0d hung=%b expected %0d 0", o_req_cycles, o_timeout, TIMEOUT);
        end
        checks++;
        if ({o_wb_valid, o_wb_we, o_misalign, o_bus_err} !== 4'b1001 || o_after !== 1'b0) begin
            failures++;
            $display("FAIL to_wb: v/we/mis/err=%b%b%b%b after=%b expected 1001 after=0",
                     o_wb_valid, o_wb_we, o_misalign, o_bus_err, o_after);
        end
        // Ack in the very last permitted cycle wins over expiry.
        run_op(32'h0000_0404, 32'h0, 4'b1010, 1'b0, 5'd8, 1'b1, TIMEOUT - 1, 32'hA5A5_1234);
        checks++;
        if (o_req_cycles !== TIMEOUT || o_bus_err !== 1'b0 || o_wb_valid !== 1'b1 ||
            o_wb_we !== 1'b1 || o_wb_data !== 32'hA5A5_1234) begin
            failures++;
            $display("FAIL to_late_ack: req=%0d err=%b valid=%b we=%b data=%h expected %0d 0 1 1 a5a51234",
                     o_req_cycles, o_bus_err, o_wb_valid, o_wb_we, o_wb_data, TIMEOUT);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] w;
        logic [3:0]  b;
        @(negedge clk);
        valid_in = 1'b1; alu_out = 32'h0000_0500; rs2_data = 32'hDEAD_BEEF;
        mem_op = 4'b1110; mem_uns = 1'b0; rd_in = 5'd3; reg_we_in = 1'b1;
        @(negedge clk);
        // Next op presented and held for the whole stall.
        alu_out = 32'h0000_CAFE; mem_op = 4'b0000; rd_in = 5'd7; reg_we_in = 1'b1;
        n = 0; w = dmem_wdata; b = dmem_be;
        while (dmem_req && n < 40) begin
            n++;
            dmem_ack = (n == 2);
            @(negedge clk);
            dmem_ack = 1'b0;
        end
        checks++;
        if (n !== 2 || w !== 32'hDEAD_BEEF || b !== 4'b1111) begin
            failures++;
            $display("FAIL b2b_sw: req_cycles=%0d wdata=%h be=%b expected 2 deadbeef 1111", n, w, b);
        end
        checks++;
        if (wb_valid !== 1'b1 || wb_we !== 1'b0 || stall_out !== 1'b0) begin
            failures++;
            $display("FAIL b2b_sw_wb: valid=%b we=%b stall=%b expected 1 0 0", wb_valid, wb_we, stall_out);
        end
        @(negedge clk);
        valid_in = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_rd !== 5'd7 ||
            wb_data !== 32'h0000_CAFE || dmem_req !== 1'b0) begin
            failures++;
            $display("FAIL b2b_alu_wb: valid=%b we=%b rd=%0d data=%h req=%b expected 1 1 7 0000cafe 0",
                     wb_valid, wb_we, wb_rd, wb_data, dmem_req);
        end
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_single: extra wb_valid=%b expected 0", wb_valid);
        end
    endtask

    task automatic test_reset_wait();
        @(negedge clk);
        valid_in = 1'b1; alu_out = 32'h0000_0600; mem_op = 4'b1010; rd_in = 5'd2; reg_we_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1) begin
            failures++; $display("FAIL rstw_pre: req=%b expected 1", dmem_req);
        end
        rst_n = 1'b0;
        dmem_ack = 1'b1;  // an ack racing the reset must not produce a writeback
        @(negedge clk);
        dmem_ack = 1'b0;
        checks++;
        if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || stall_out !== 1'b0) begin
            failures++;
            $display("FAIL rstw_drop: req=%b wb_valid=%b stall=%b expected 0 0 0", dmem_req, wb_valid, stall_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
            failures++; $display("FAIL rstw_after: wb_valid=%b req=%b expected 0 0", wb_valid, dmem_req);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d, rdata, e_data;
        logic [4:0]  rd;
        logic        we, uns, st, mem, mis, to, chk_data;
        int          sz, ack_after, e_req;
        for (int i = 0; i < 40; i++) begin
            a = $urandom; d = $urandom; rdata = $urandom;
            rd = 5'($urandom_range(0, 31)); we = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1)); st = 1'($urandom_range(0, 1));
            sz = $urandom_range(0, 2); mem = ($urandom_range(0, 3) != 0);
            if (mem && $urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            ack_after = $urandom_range(0, 5);
            if ($urandom_range(0, 7) == 0) ack_after = $urandom_range(TIMEOUT - 2, TIMEOUT + 3);

            mis = mem && m_misalign(sz, a);
            to = mem && !mis && (ack_after >= TIMEOUT);
            e_req = (!mem || mis) ? 0 : (to ? TIMEOUT : ack_after + 1);
            chk_data = !mem || (!mis && !to && !st);
            e_data = !mem ? a : m_load(sz, uns, a, rdata);
            if (chk_data) exp_q.push_back(e_data);

            run_op(a, d, {mem, st, 2'(sz)}, uns, rd, we, ack_after, rdata);

            checks++;
            if (o_req_cycles !== e_req || o_unstable !== 1'b0 || o_stall_bad !== 1'b0) begin
                failures++;
                $display("FAIL rnd_req[%0d]: req=%0d unstable=%b stall_bad=%b expected %0d 0 0",
                         i, o_req_cycles, o_unstable, o_stall_bad, e_req);
            end
            checks++;
            if ({o_wb_valid, o_wb_we, o_misalign, o_bus_err, o_after} !==
                {1'b1, (!mis && !to && (!mem || !st)) ? we : 1'b0, mis, to, 1'b0}) begin
                failures++;
                $display("FAIL rnd_flags[%0d]: v/we/mis/err/after=%b%b%b%b%b mis_exp=%b to_exp=%b",
                         i, o_wb_valid, o_wb_we, o_misalign, o_bus_err, o_after, mis, to);
            end
            if (e_req != 0) begin
                checks++;
                if (o_addr !== {a[31:2], 2'b00} || o_be !== m_be(sz, a) || o_we !== st ||
                    (st && o_wdata !== m_wdata(sz, d))) begin
                    failures++;
                    $display("FAIL rnd_bus[%0d]: addr=%h be=%b we=%b wdata=%h expected %h %b %b %h",
                             i, o_addr, o_be, o_we, o_wdata, {a[31:2], 2'b00}, m_be(sz, a), st, m_wdata(sz, d));
                end
            end
            if (chk_data) begin
                e_data = exp_q.pop_front();
                checks++;
                if (o_wb_data !== e_data || o_wb_rd !== rd) begin
                    failures++;
                    $display("FAIL rnd_data[%0d]: data=%h rd=%0d expected %h %0d",
                             i, o_wb_data, o_wb_rd, e_data, rd);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_reset_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
